// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: shared types for the DDR3 port arbiter (owner id, FSM states, read tag record).
package ddr3_arb_pkg;
    localparam int ARB_BURST_W = 4;
    typedef logic owner_t;
    typedef enum logic [1:0] {IDLE, CMD, WBURST} state_t;
    typedef struct packed {
        owner_t                 owner;
        logic [ARB_BURST_W-1:0] burstcount;
    } rd_tag_t;
endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// ddr3_arb_tag_fifo: synchronous FIFO of outstanding read tags.
//  clk/reset: clock and sync active-high reset; push/din: enqueue (ignored when full)
//  pop: dequeue (ignored when empty); head: oldest tag; full/empty: occupancy flags
module ddr3_arb_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  rd_tag_t din,
    output rd_tag_t head,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);
    rd_tag_t mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    // extra pointer bit distinguishes full from empty
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = wp == rp;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter: shares one DDR3 Avalon-MM burst port between m0 (priority) and m1.
//  mN_*: master-side Avalon-MM slave ports; s_*: master port to the DDR3 controller.
//  Write grants persist for the whole burst; read tags route each returned beat to its issuer.
//  Optional ARB_STARVE_GUARD_EN: m1 gets a forced grant after MAX_WAIT consecutive denials.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 128,
    parameter int BURST_W   = ARB_BURST_W,
    parameter int MAX_OUTST = 8
`ifdef ARB_STARVE_GUARD_EN
    , parameter int MAX_WAIT = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [BURST_W-1:0]  m0_burstcount,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [BURST_W-1:0]  m1_burstcount,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [BURST_W-1:0]  s_burstcount,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid
);
    state_t state, state_nxt;
    owner_t owner, owner_nxt;
    logic [BURST_W-1:0] wcnt, wcnt_nxt, rcnt;
    rd_tag_t tag_in, head;
    logic full, empty, push, pop, rd_hit, wacc;
    logic own_read, own_write, req0, req1, grant1;

    assign s_address    = owner ? m1_address : m0_address;
    assign s_burstcount = owner ? m1_burstcount : m0_burstcount;
    assign s_writedata  = owner ? m1_writedata : m0_writedata;
    assign s_byteenable = owner ? m1_byteenable : m0_byteenable;
    assign own_read     = owner ? m1_read : m0_read;
    assign own_write    = owner ? m1_write : m0_write;
    assign s_read       = state == CMD && own_read;
    assign s_write      = state != IDLE && own_write;
    assign m0_waitrequest = state == IDLE || owner || s_waitrequest;
    assign m1_waitrequest = state == IDLE || !owner || s_waitrequest;

    // a read only competes when its tag is guaranteed a FIFO slot
    assign req0 = m0_write || (m0_read && !full);
    assign req1 = m1_write || (m1_read && !full);
    assign push = s_read && !s_waitrequest;
    assign wacc = s_write && !s_waitrequest;
    assign tag_in = '{owner: owner, burstcount: s_burstcount};

`ifdef ARB_STARVE_GUARD_EN
    localparam int DW = $clog2(MAX_WAIT + 1);
    logic [DW-1:0] denied;
    assign grant1 = req1 && (!req0 || denied == DW'(MAX_WAIT));
    always_ff @(posedge clk) begin
        if (reset) denied <= '0;
        else if (state == IDLE && req1)
            denied <= grant1 ? '0 : (denied == DW'(MAX_WAIT) ? denied : denied + 1'b1);
    end
`else
    assign grant1 = req1 && !req0;
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: if (req0 || req1) begin
                state_nxt = CMD;
                owner_nxt = grant1;
            end
            CMD: if (!own_read && !own_write || push) begin
                state_nxt = IDLE;
            end else if (wacc) begin
                state_nxt = s_burstcount == BURST_W'(1) ? IDLE : WBURST;
                wcnt_nxt  = s_burstcount - 1'b1;
            end
            default: if (wacc) begin
                wcnt_nxt  = wcnt - 1'b1;
                state_nxt = wcnt == BURST_W'(1) ? IDLE : WBURST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            wcnt  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            wcnt  <= wcnt_nxt;
            rcnt  <= pop ? '0 : rd_hit ? rcnt + 1'b1 : rcnt;
        end
    end

    // beats arriving with no outstanding tag are dropped
    assign rd_hit = s_readdatavalid && !empty;
    assign pop    = rd_hit && (rcnt + 1'b1) == head.burstcount;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = rd_hit && !head.owner;
    assign m1_readdatavalid = rd_hit && head.owner;

    ddr3_arb_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (tag_in),
        .head  (head),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// tb_ddr3_port_arbiter: directed self-checking bench for ddr3_port_arbiter.
module tb_ddr3_port_arbiter;
    logic clk = 0, reset;
    logic [26:0] m0_address, m1_address, s_address;
    logic m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [3:0] m0_burstcount, m1_burstcount, s_burstcount;
    logic [127:0] m0_writedata, m1_writedata, s_writedata;
    logic [15:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic m0_waitrequest, m1_waitrequest, s_waitrequest;
    logic [127:0] m0_readdata, m1_readdata, s_readdata;
    logic m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
    int total = 0, bad = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e0;
        logic       e1;
    } rvec_t;
    rvec_t rv [10];

    always #5 clk = ~clk;

    ddr3_port_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_burstcount(s_burstcount),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        int k;
        logic exp1;
        rv[0] = '{1'b1, 8'h10, 1'b1, 1'b0};
        rv[1] = '{1'b1, 8'h11, 1'b1, 1'b0};
        rv[2] = '{1'b1, 8'h12, 1'b1, 1'b0};
        rv[3] = '{1'b1, 8'h13, 1'b1, 1'b0};
        rv[4] = '{1'b0, 8'h00, 1'b0, 1'b0};
        rv[5] = '{1'b1, 8'h20, 1'b0, 1'b1};
        rv[6] = '{1'b1, 8'h21, 1'b0, 1'b1};
        rv[7] = '{1'b1, 8'h22, 1'b0, 1'b1};
        rv[8] = '{1'b1, 8'h23, 1'b0, 1'b1};
        rv[9] = '{1'b1, 8'h99, 1'b0, 1'b0};

        reset = 1;
        {m0_address, m0_read, m0_write, m0_burstcount, m0_writedata, m0_byteenable} = '0;
        {m1_address, m1_read, m1_write, m1_burstcount, m1_writedata, m1_byteenable} = '0;
        {s_waitrequest, s_readdata, s_readdatavalid} = '0;
        cyc(); cyc();
        reset = 0;
        #2;
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);

        // both masters read burst 4 together: m0 first, then m1
        m0_address = 27'h100; m0_burstcount = 4; m0_read = 1;
        m1_address = 27'h200; m1_burstcount = 4; m1_read = 1;
        #2;
        chk("t1_idle_s_read", s_read, 0);
        chk("t1_idle_m0_wait", m0_waitrequest, 1);
        cyc(); #2;
        chk("t1_cmd0_s_read", s_read, 1);
        chk("t1_cmd0_addr", s_address, 27'h100);
        chk("t1_cmd0_m0_wait", m0_waitrequest, 0);
        chk("t1_cmd0_m1_wait", m1_waitrequest, 1);
        cyc(); m0_read = 0; #2;
        chk("t1_gap_s_read", s_read, 0);
        cyc(); #2;
        chk("t1_cmd1_addr", s_address, 27'h200);
        chk("t1_cmd1_m1_wait", m1_waitrequest, 0);
        chk("t1_cmd1_m0_wait", m0_waitrequest, 1);
        cyc(); m1_read = 0;
        for (int i = 0; i < 10; i++) begin
            s_readdatavalid = rv[i].v;
            s_readdata = 128'(rv[i].d);
            #2;
            chk("t1_rv_m0", m0_readdatavalid, rv[i].e0);
            chk("t1_rv_m1", m1_readdatavalid, rv[i].e1);
            if (rv[i].v) chk("t1_rdata_m1", m1_readdata, 128'(rv[i].d));
            cyc();
        end
        s_readdatavalid = 0;

        // m1 write burst 8 holds the grant while m0 read waits
        m1_address = 27'h300; m1_burstcount = 8; m1_write = 1; m1_byteenable = '1;
        cyc();
        m0_address = 27'h400; m0_burstcount = 1; m0_read = 1;
        for (int b = 0; b < 8; b++) begin
            m1_writedata = 128'(32'hA0 + b);
            #2;
            chk("t2_s_write", s_write, 1);
            chk("t2_wdata", s_writedata, 128'(32'hA0 + b));
            chk("t2_addr", s_address, 27'h300);
            chk("t2_s_read", s_read, 0);
            chk("t2_m0_wait", m0_waitrequest, 1);
            chk("t2_m1_wait", m1_waitrequest, 0);
            cyc();
        end
        m1_write = 0; #2;
        chk("t2_end_s_write", s_write, 0);
        chk("t2_end_s_read", s_read, 0);
        cyc(); #2;
        chk("t2_m0_cmd", s_read, 1);
        chk("t2_m0_addr", s_address, 27'h400);
        cyc(); m0_read = 0; s_readdatavalid = 1; s_readdata = 128'h55; #2;
        chk("t2_rv_m0", m0_readdatavalid, 1);
        chk("t2_rv_m1", m1_readdatavalid, 0);
        cyc(); s_readdatavalid = 0;

        // m1 fills the tag FIFO with 8 single-beat reads; the 9th stalls
        m1_address = 27'h500; m1_burstcount = 1; m1_read = 1;
        for (int i = 0; i < 8; i++) begin
            cyc(); #2;
            chk("t3_cmd", s_read, 1);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t3_full_s_read", s_read, 0);
            chk("t3_full_m1_wait", m1_waitrequest, 1);
            cyc();
        end
        s_readdatavalid = 1; #2;
        chk("t3_rv_m1", m1_readdatavalid, 1);
        chk("t3_rv_m0", m0_readdatavalid, 0);
        cyc(); s_readdatavalid = 0; #2;
        chk("t3_decide_s_read", s_read, 0);
        cyc(); #2;
        chk("t3_ninth_cmd", s_read, 1);
        cyc(); m1_read = 0; s_readdatavalid = 1;
        for (int i = 0; i < 8; i++) begin
            #2;
            chk("t3_drain_m1", m1_readdatavalid, 1);
            cyc();
        end
        s_readdatavalid = 0; #2;
        chk("t3_drained", m1_readdatavalid, 0);

        // controller stall during CMD
        s_waitrequest = 1;
        m0_address = 27'h600; m0_burstcount = 2; m0_read = 1;
        m1_address = 27'h700; m1_burstcount = 1; m1_write = 1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("t4_m0_wait", m0_waitrequest, 1);
            chk("t4_m1_wait", m1_waitrequest, 1);
            chk("t4_s_read", s_read, 1);
            chk("t4_addr", s_address, 27'h600);
            chk("t4_bc", s_burstcount, 2);
            cyc();
        end
        s_waitrequest = 0; #2;
        chk("t4_m0_go", m0_waitrequest, 0);
        chk("t4_m1_hold", m1_waitrequest, 1);
        cyc(); m0_read = 0; m1_write = 0; s_readdatavalid = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("t4_rv_m0", m0_readdatavalid, 1);
            cyc();
        end
        s_readdatavalid = 0;

        // reset during an m1 write burst with a read tag outstanding
        m0_address = 27'h800; m0_burstcount = 1; m0_read = 1;
        cyc(); cyc(); m0_read = 0;
        m1_address = 27'h900; m1_burstcount = 8; m1_write = 1;
        cyc(); cyc(); cyc();
        #2;
        chk("t5_midburst", s_write, 1);
        reset = 1;
        cyc(); reset = 0; m1_write = 0; #2;
        chk("t5_s_write", s_write, 0);
        chk("t5_s_read", s_read, 0);
        chk("t5_m0_wait", m0_waitrequest, 1);
        chk("t5_m1_wait", m1_waitrequest, 1);
        s_readdatavalid = 1; #1;
        chk("t5_rv_m0", m0_readdatavalid, 0);
        chk("t5_rv_m1", m1_readdatavalid, 0);
        cyc(); s_readdatavalid = 0;

        // m0 reads back-to-back while m1 keeps requesting
        m0_address = 27'h900; m0_burstcount = 1; m0_read = 1;
        m1_address = 27'hA00; m1_burstcount = 1; m1_read = 1;
        s_readdatavalid = 1;
        k = 0;
        for (int c = 0; c < 60 && k < 20; c++) begin
            #2;
            if (s_read) begin
                k++;
`ifdef ARB_STARVE_GUARD_EN
                exp1 = k == 17;
`else
                exp1 = 0;
`endif
                chk("t6_m1_grant", !m1_waitrequest, exp1);
                chk("t6_addr", s_address, exp1 ? 27'hA00 : 27'h900);
            end
            cyc();
        end
        chk("t6_decisions", k, 20);
        m0_read = 0; m1_read = 0; s_readdatavalid = 0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
